instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//  Parametrised successor to the 4-wide fixed instruction-memory front end. Issues dual-line reads to a
//  synchronous dual-port I-memory, extracts FETCH_W consecutive instructions from any PC alignment, and
//  buffers them with their PCs in a circular queue. Decode pops 0..FETCH_W per cycle.
//  Branch/exception redirect flushes the queue and any in-flight read.
// PARAMETERS
//  INST_W     16  instruction width in bits
//  LINE_WORDS 4   instructions per memory line (power of 2, >=2)
//  FETCH_W    4   instructions fetched/presented per cycle (1..LINE_WORDS)
//  PC_W       16  PC width; word-addressed (PC+1 = next instruction)
//  DEPTH      16  queue entries (power of 2, >= 2*FETCH_W; full throughput needs >= 3*FETCH_W)
//  RESET_PC   0   fetch PC after reset
// PORTS
//  clk          in   1                   clock, rising edge
//  rst_n        in   1                   asynchronous active-low reset
//  redirect     in   1                   flush queue, restart fetch at redirect_pc
//  redirect_pc  in   PC_W                new fetch PC
//  mem_en       out  1                   read enable, both memory ports
//  mem_addr0    out  PC_W-log2(LW)       line address of fetch_pc
//  mem_addr1    out  PC_W-log2(LW)       line address of fetch_pc+FETCH_W-1
//  mem_line0    in   INST_W*LINE_WORDS   port-0 data, valid cycle after mem_en; word 0 at MSBs
//  mem_line1    in   INST_W*LINE_WORDS   port-1 data, same timing
//  out_inst     out  FETCH_W*INST_W      queue head..head+FETCH_W-1; slot 0 at LSBs
//  out_pc       out  FETCH_W*PC_W        PC of each out_inst slot
//  out_valid    out  FETCH_W             thermometer: bit i = (count > i)
//  deq_cnt      in   log2(FETCH_W)+1     entries consumed this cycle
//  fetch_pc     out  PC_W                next PC to issue (debug/branch-predict hook)
// BEHAVIOUR
//  - Reset (async, rst_n=0): fetch_pc=RESET_PC, count=0, head=tail=0, inflight=0.
//    Outputs: mem_en=0, out_valid=0; out_inst/out_pc=0 (queue storage cleared).
//  - Issue: mem_en=1 when !redirect && (DEPTH - count - (inflight ? FETCH_W : 0)) >= FETCH_W, count being the
//    registered count. On issue: fetch_pc += FETCH_W (mod 2^PC_W), and inflight <= 1 with the issued PC.
//    Otherwise inflight <= 0.
//  - Return: the cycle after issue, if inflight, push FETCH_W entries. Entry k: pc = ipc+k, off = ipc[log2(LW)-1:0].
//    Source: word off+k of mem_line0 if off+k < LINE_WORDS, else word off+k-LINE_WORDS of mem_line1.
//  - mem_addr1 wraps to line 0 past top of PC space; when both addresses are equal, only line0 words are used.
//  - Pop: effective pop = min(deq_cnt, popcount(out_valid)); over-request is clamped, never underflows.
//    Push and pop in the same cycle: count <= count + push - pop. head/tail wrap mod DEPTH.
//  - Redirect (priority over issue, return, pop): count<=0, head<=tail, inflight<=0 (returning data discarded),
//    fetch_pc<=redirect_pc, mem_en=0 that cycle.
//    Latency: redirect in cycle T -> mem_en in T+1 -> push at end of T+2 -> out_valid in T+3.
//  - Queue never overflows: the issue credit reserves space for the in-flight line.
//  - Steady state (DEPTH >= 3*FETCH_W, deq_cnt=FETCH_W every cycle): FETCH_W instructions per cycle, no bubbles.
//  - Outputs out_* are combinational from queue state (registered storage), not from deq_cnt.
// STRUCTURE
//  - fetch_defs.vh: localparams derived from parameters (OFF_W=log2(LW), LADDR_W, CNT_W, PTR_W),
//    plus clog2 function.
//  - Sub-module fetch_align (combinational): ipc offset + two lines -> FETCH_W instructions.
//    Reusable by the I-cache refill path.
//  - Top: fetch_pc/inflight registers, credit/issue logic, circular storage (inst+pc), head/tail/count.
// TESTING
//  1 Reset then run, deq_cnt=4, memory word n = 16'hA000+n: out_valid=4'b1111 from cycle 3.
//    out_pc 0,1,2,3 then 4..7, one group per cycle, no gaps.
//  2 redirect_pc=16'h0006: mem_addr0=1, mem_addr1=2; out_inst = words 6,7,8,9 (line-crossing).
//    Repeat with pc=5 and pc=7 for all offsets.
//  3 deq_cnt=0 held: pushes stop with count=16, mem_en deasserts, no overwrite.
//    deq_cnt=2 then resumes in-order delivery.
//  4 redirect to 16'h0040 in the same cycle as a return and deq_cnt=4:
//    queue empties, stale data dropped; next out_pc[0]=16'h0040 exactly 3 cycles later.
//  5 redirect_pc=16'hFFFE: group PCs FFFE,FFFF,0000,0001; mem_addr1=0.
//    deq_cnt=4 with only 2 valid: count goes to 0, never negative.
//  6 Assert rst_n=0 mid-stream between edges: out_valid=0 and mem_en=0 immediately.
//    After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared helpers for the instruction fetch queue and its line aligner.
package instr_fetch_queue_pkg;

  // Ceiling log2. The result is 0 for values of 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        result = result + 1;
        v = v >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_align.sv
// Combinational line aligner: picks FETCH_W consecutive instructions that start at a word
// offset inside line0 and may spill over into line1. Word 0 of each line sits at the MSBs,
// and output slot 0 sits at the LSBs.
module instr_fetch_queue_align
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned INST_W     = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned FETCH_W    = 4,
  localparam int unsigned OFF_W     = clog2(LINE_WORDS)
) (
  input  logic [OFF_W-1:0]             i_off,
  input  logic [INST_W*LINE_WORDS-1:0] i_line0,
  input  logic [INST_W*LINE_WORDS-1:0] i_line1,
  output logic [FETCH_W*INST_W-1:0]    o_inst
);

  localparam int unsigned SEL_W = OFF_W + 1;

  logic [INST_W-1:0] w_words [2*LINE_WORDS];

  // Unpack both lines into one contiguous word array: line0 words, then line1 words.
  always_comb begin
    for (int unsigned j = 0; j < LINE_WORDS; j++) begin
      w_words[j]            = i_line0[(LINE_WORDS-1-j)*INST_W +: INST_W];
      w_words[LINE_WORDS+j] = i_line1[(LINE_WORDS-1-j)*INST_W +: INST_W];
    end
  end

  // Slot k takes word off+k of the concatenation; FETCH_W <= LINE_WORDS keeps it in range.
  always_comb begin
    logic [SEL_W-1:0] w_sel;
    o_inst = '0;
    w_sel  = '0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      w_sel = {1'b0, i_off} + SEL_W'(k);
      o_inst[k*INST_W +: INST_W] = w_words[w_sel];
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues dual-line reads, aligns FETCH_W instructions from any PC,
// and buffers them with their PCs in a circular queue that decode pops 0..FETCH_W per cycle.
// A redirect flushes the queue and drops any read already in flight.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned    INST_W     = 16,
  parameter int unsigned    LINE_WORDS = 4,
  parameter int unsigned    FETCH_W    = 4,
  parameter int unsigned    PC_W       = 16,
  parameter int unsigned    DEPTH      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  localparam int unsigned   OFF_W      = clog2(LINE_WORDS),
  localparam int unsigned   LADDR_W    = PC_W - OFF_W,
  localparam int unsigned   DEQ_W      = clog2(FETCH_W) + 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_redirect,
  input  logic [PC_W-1:0]              i_redirect_pc,
  output logic                         o_mem_en,
  output logic [LADDR_W-1:0]           o_mem_addr0,
  output logic [LADDR_W-1:0]           o_mem_addr1,
  input  logic [INST_W*LINE_WORDS-1:0] i_mem_line0,
  input  logic [INST_W*LINE_WORDS-1:0] i_mem_line1,
  output logic [FETCH_W*INST_W-1:0]    o_out_inst,
  output logic [FETCH_W*PC_W-1:0]      o_out_pc,
  output logic [FETCH_W-1:0]           o_out_valid,
  input  logic [DEQ_W-1:0]             i_deq_cnt,
  output logic [PC_W-1:0]              o_fetch_pc
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [PC_W-1:0]   r_fetch_pc;
  logic              r_inflight;
  logic [PC_W-1:0]   r_ipc;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [PC_W-1:0]   r_pc   [DEPTH];

  logic [CNT_W:0]            w_used;
  logic                      w_issue;
  logic                      w_push;
  logic [CNT_W-1:0]          w_avail;
  logic [CNT_W-1:0]          w_deq;
  logic [CNT_W-1:0]          w_pop;
  logic [PC_W-1:0]           w_last_pc;
  logic [FETCH_W*INST_W-1:0] w_align;

  // Occupied slots plus the slots reserved for the line that is still in flight.
  assign w_used = {1'b0, r_count} + (r_inflight ? (CNT_W+1)'(FETCH_W) : '0);

  // Reset gates the enable directly so it drops as soon as rst_n falls, not at the next edge.
  assign w_issue = i_rst_n & ~i_redirect & (w_used <= (CNT_W+1)'(DEPTH - FETCH_W));
  assign w_push  = r_inflight & ~i_redirect;

  // Clamp the pop to what is actually presented on out_valid.
  assign w_avail = (r_count > CNT_W'(FETCH_W)) ? CNT_W'(FETCH_W) : r_count;
  assign w_deq   = CNT_W'(i_deq_cnt);
  assign w_pop   = (w_deq < w_avail) ? w_deq : w_avail;

  // Line addresses of the first and last instruction of the group; addr1 wraps past the top.
  assign w_last_pc   = r_fetch_pc + PC_W'(FETCH_W - 1);
  assign o_mem_en    = w_issue;
  assign o_mem_addr0 = r_fetch_pc[PC_W-1:OFF_W];
  assign o_mem_addr1 = w_last_pc[PC_W-1:OFF_W];
  assign o_fetch_pc  = r_fetch_pc;

  instr_fetch_queue_align #(
    .INST_W     (INST_W),
    .LINE_WORDS (LINE_WORDS),
    .FETCH_W    (FETCH_W)
  ) u_align (
    .i_off   (r_ipc[OFF_W-1:0]),
    .i_line0 (i_mem_line0),
    .i_line1 (i_mem_line1),
    .o_inst  (w_align)
  );

  // Fetch PC, in-flight tracking and queue pointers; redirect overrides issue, return and pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_ipc      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (i_redirect) begin
      r_fetch_pc <= i_redirect_pc;
      r_inflight <= 1'b0;
      r_head     <= r_tail;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(FETCH_W);
        r_ipc      <= r_fetch_pc;
      end
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + (w_push ? PTR_W'(FETCH_W) : '0);
      r_count <= r_count + (w_push ? CNT_W'(FETCH_W) : '0) - w_pop;
    end
  end

  // Queue storage: the returning group is written at tail with consecutive PCs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        r_inst[e] <= '0;
        r_pc[e]   <= '0;
      end
    end else if (w_push) begin
      for (int unsigned k = 0; k < FETCH_W; k++) begin
        r_inst[r_tail + PTR_W'(k)] <= w_align[k*INST_W +: INST_W];
        r_pc[r_tail + PTR_W'(k)]   <= r_ipc + PC_W'(k);
      end
    end
  end

  // Present head..head+FETCH_W-1 straight from storage; valid is a thermometer of count.
  always_comb begin
    logic [PTR_W-1:0] w_rd;
    o_out_inst  = '0;
    o_out_pc    = '0;
    o_out_valid = '0;
    w_rd        = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      w_rd = r_head + PTR_W'(i);
      o_out_inst[i*INST_W +: INST_W] = r_inst[w_rd];
      o_out_pc[i*PC_W +: PC_W]       = r_pc[w_rd];
      o_out_valid[i]                 = (r_count > CNT_W'(i));
    end
  end

endmodule
